led_controller_nch: RTL and testbench
=====================================

# led_controller_nch

Parametrised N-channel LED controller with per-channel PWM dimming and hardware brightness fading. It is the successor to the fixed four-LED controller: the register file holds mode, fade rate, per-channel PWM targets and per-channel output modes. All LED waveforms are generated from one system clock with an internal prescaler. It sits between the register bus and the LED pins.

## Interface
- `NUM_LEDS`, default 8: channel count, 1..32.
- `DATA_BITS`, default 8: register and duty width. The PWM period is 2^DATA_BITS ticks.
- `PRESCALE`, default 64: system clocks per PWM tick, ≥1.
- `ADDR_BITS`, derived (localparam): clog2(2 + NUM_LEDS + ceil(NUM_LEDS/4)).
- `clk` input 1: system clock, all logic on its rising edge.
- `reset` input 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `w_en` input 1: write strobe, one register written per asserted cycle.
- `r_en` input 1: read strobe.
- `addr` input ADDR_BITS: register address.
- `wdata` input DATA_BITS: write data.
- `rdata` output DATA_BITS: read data, registered.
- `rvalid` output 1: high for the one cycle in which `rdata` is valid.
- `leds` output NUM_LEDS: LED drive, registered.

## Operation
- **Address map**
  - 0 MODE: bit0 sleep, bit1 invert, bit2 fade_en; other bits read 0.
  - 1 FADERATE.
  - 2..2+N-1 TARGET[i].
  - Next ceil(N/4) addresses LEDOUT: 2 bits per channel, LSB-first, 4 channels per byte.
  - Unused LEDOUT bits and unmapped addresses read 0; writes to them are ignored.
- **LEDOUT modes:** 00 off, 01 fully on, 10 PWM, 11 reserved (treated as off).
- **Prescaler:** counts 0..PRESCALE-1. `tick` is asserted on the terminal count.
- **PWM counter:** DATA_BITS wide, increments on `tick`, wraps from max to 0.
- **PWM output:** channel i is on while pwm_cnt < DUTY[i]. DUTY=0 is always off; DUTY=max gives (2^DATA_BITS−1)/2^DATA_BITS.
- **fade_en=0:** DUTY[i] is loaded from TARGET[i] every cycle.
- **fade_en=1:**
  - A period counter counts PWM-period wraps (tick with pwm_cnt at max).
  - When it reaches FADERATE it clears, and every DUTY[i] ≠ TARGET[i] moves by exactly 1 toward TARGET[i].
  - FADERATE=0 means one step every period.
  - There is no overshoot and no wrap-around of DUTY.
- **Sleep:**
  - Prescaler, PWM counter and period counter are held at 0, and DUTY is frozen.
  - `leds` = 0 regardless of invert.
  - The register file remains readable and writable.
  - Leaving sleep resumes the waveform from pwm_cnt=0.
- **Invert:** applied last, as `leds` = raw XOR {N{invert}}, except during sleep.
- **Bus:**
  - Write at cycle t updates the register at t+1.
  - A read at cycle t returns the register value at t on `rdata`/`rvalid` at t+1.
  - Simultaneous `w_en` and `r_en` to the same address returns the old value.
  - `rdata` holds its last value when `rvalid`=0.

## Timing
- **Reset:** all registers, DUTY, counters, `rdata`, `rvalid` and `leds` are 0 the cycle after `reset` is sampled high. Reset mid-fade abandons the fade; DUTY is 0.
- **Mode write latency:** LEDOUT or MODE (invert/sleep) written at t changes `leds` at t+2 (register at t+1, output register at t+2).
- **Target write latency, fade_en=0:** TARGET written at t gives DUTY at t+2, which affects `leds` from the next compare, at t+3 at the earliest.
- **Full fade length:** a fade from 0 to 255 takes 255 × (FADERATE+1) PWM periods. Each period is 2^DATA_BITS × PRESCALE clocks.
- **Target change mid-fade:** the new target takes effect at the next step, which moves toward the new target.

## Structure
- **`led_driver_pkg` additions:**
  - Address constants `REG_MODE_N`=0 and `REG_FADERATE`=1.
  - `TARGET_BASE` and `LEDOUT_BASE(N)` as a function.
  - `ledout_mode_t` enum {LED_OFF, LED_ON, LED_PWM, LED_RSVD}.
  - Packed struct `mode_n_t` {sleep, invert, fade_en}.
- **Sub-module `led_fade_channel`:**
  - One instance per channel, via generate.
  - Holds DUTY, takes step/target/fade_en/pwm_cnt/mode and produces the raw channel output.
- **Top level:** keeps the register file, prescaler, PWM counter, period counter, read port and invert/sleep gating.

## Test plan
- **Reset and readback:** reset, then read all addresses. Expect 0, with `rvalid` one cycle after each `r_en`. Write TARGET[3]=0x80, read → 0x80. Write to an unmapped address, read → 0.
- **Static modes:** N=8, PRESCALE=2, LEDOUT ch0=01, ch1=00, ch2=11. Expect `leds`[0]=1, [1]=0, [2]=0 constant. Set invert → [0]=0, [1]=1, [2]=1 at t+2.
- **PWM duty:** ch0 PWM, TARGET=64, fade_en=0. Expect `leds`[0] high for exactly 64×PRESCALE of every 256×PRESCALE clocks. TARGET=0 → never high; TARGET=255 → low for PRESCALE clocks per period.
- **Fade:** fade_en=1, FADERATE=1, TARGET[0] 0→4. Expect DUTY 1,2,3,4 after period wraps 2,4,6,8, then stable. Retarget to 2 mid-fade at DUTY=3 → next step gives 2.
- **Sleep:** sleep with invert=1 mid-fade → `leds`=0 and DUTY frozen. Write TARGET during sleep, read it back correctly. Wake → waveform restarts at pwm_cnt=0.
- **Collisions and reset:** same-cycle write+read of address 2 returns the old value. Reset asserted mid-fade → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/led_controller_nch_pkg.sv
// Shared types, register map constants and sizing helpers for the N-channel LED controller.
package led_controller_nch_pkg;

    localparam int REG_MODE_N   = 0;
    localparam int REG_FADERATE = 1;
    localparam int TARGET_BASE  = 2;

    typedef enum logic [1:0] {
        LED_OFF  = 2'b00,
        LED_ON   = 2'b01,
        LED_PWM  = 2'b10,
        LED_RSVD = 2'b11
    } ledout_mode_t;

    // Field order puts sleep in bit 0, invert in bit 1, fade_en in bit 2.
    typedef struct packed {
        logic fade_en;
        logic invert;
        logic sleep;
    } mode_n_t;

    function automatic int ledout_base(input int num_leds);
        return TARGET_BASE + num_leds;
    endfunction

    function automatic int ledout_regs(input int num_leds);
        return (num_leds + 3) / 4;
    endfunction

    function automatic int addr_bits(input int num_leds);
        return $clog2(TARGET_BASE + num_leds + ledout_regs(num_leds));
    endfunction

endpackage

// File: rtl/led_controller_nch_if.sv
// Register bus between a host and the LED controller.
interface led_controller_nch_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
);
    // Strobe semantics: w_en writes wdata to addr in that cycle; r_en requests addr and
    // the value appears on rdata with rvalid high exactly one cycle later. No backpressure.
    logic                 w_en;
    logic                 r_en;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 rvalid;

    modport master (output w_en, r_en, addr, wdata, input rdata, rvalid);
    modport slave  (input w_en, r_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/led_controller_nch_fade_channel.sv
// One LED channel: holds DUTY, fades it toward TARGET one step at a time, and compares it with the PWM counter.
module led_fade_channel
    import led_controller_nch_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sleep_i,
    input  logic                 step_i,
    input  logic                 fade_en_i,
    input  logic [DATA_BITS-1:0] target_i,
    input  logic [DATA_BITS-1:0] pwm_cnt_i,
    input  ledout_mode_t         mode_i,
    output logic                 raw_o
);

    localparam logic [DATA_BITS-1:0] ONE = DATA_BITS'(1);

    logic [DATA_BITS-1:0] duty_q;
    logic [DATA_BITS-1:0] duty_d;

    always_comb begin
        duty_d = duty_q;
        if (!sleep_i) begin
            if (!fade_en_i) begin
                duty_d = target_i;
            end else if (step_i) begin
                if (duty_q < target_i) begin
                    duty_d = duty_q + ONE;
                end else if (duty_q > target_i) begin
                    duty_d = duty_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    // Reserved mode behaves like off.
    always_comb begin
        raw_o = 1'b0;
        case (mode_i)
            LED_ON:  raw_o = 1'b1;
            LED_PWM: raw_o = (pwm_cnt_i < duty_q);
            default: raw_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_controller_nch.sv
// N-channel LED controller: register file, prescaler, PWM and fade-period counters, read port and output gating.
module led_controller_nch
    import led_controller_nch_pkg::*;
#(
    parameter int NUM_LEDS  = 8,
    parameter int DATA_BITS = 8,
    parameter int PRESCALE  = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    led_controller_nch_if.slave  bus,
    output logic [NUM_LEDS-1:0]  leds
);

    localparam int ADDR_BITS   = addr_bits(NUM_LEDS);
    localparam int LEDOUT_BASE = ledout_base(NUM_LEDS);
    localparam int PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [ADDR_BITS-1:0] addr;
    assign addr = bus.addr;

    mode_n_t              mode_q;
    logic [DATA_BITS-1:0] faderate_q;
    logic [DATA_BITS-1:0] target_q [NUM_LEDS];
    ledout_mode_t         ledout_q [NUM_LEDS];

    // LEDOUT packing assumes DATA_BITS >= 8 so four 2-bit fields fit in one register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= '0;
            faderate_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                target_q[i] <= '0;
                ledout_q[i] <= LED_OFF;
            end
        end else if (bus.w_en) begin
            if (addr == ADDR_BITS'(REG_MODE_N)) begin
                mode_q <= mode_n_t'(bus.wdata[2:0]);
            end
            if (addr == ADDR_BITS'(REG_FADERATE)) begin
                faderate_q <= bus.wdata;
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (addr == ADDR_BITS'(TARGET_BASE + i)) begin
                    target_q[i] <= bus.wdata;
                end
                if (addr == ADDR_BITS'(LEDOUT_BASE + i / 4)) begin
                    ledout_q[i] <= ledout_mode_t'(bus.wdata[2*(i%4) +: 2]);
                end
            end
        end
    end

    logic [PW-1:0]        presc_q, presc_d;
    logic [DATA_BITS-1:0] pwm_q, pwm_d;
    logic [DATA_BITS-1:0] per_q, per_d;
    logic                 tick;
    logic                 wrap;
    logic                 step;

    assign tick = (presc_q == PW'(PRESCALE - 1));
    assign wrap = tick && (pwm_q == '1);
    assign step = !mode_q.sleep && mode_q.fade_en && wrap && (per_q >= faderate_q);

    always_comb begin
        presc_d = presc_q + PW'(1);
        pwm_d   = pwm_q;
        per_d   = per_q;
        if (tick) begin
            presc_d = '0;
            pwm_d   = pwm_q + DATA_BITS'(1);
        end
        if (!mode_q.fade_en) begin
            per_d = '0;
        end else if (wrap) begin
            per_d = (per_q >= faderate_q) ? '0 : per_q + DATA_BITS'(1);
        end
        // Sleep parks every counter so waking restarts the waveform from pwm_cnt=0.
        if (mode_q.sleep) begin
            presc_d = '0;
            pwm_d   = '0;
            per_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            pwm_q   <= '0;
            per_q   <= '0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            per_q   <= per_d;
        end
    end

    logic [NUM_LEDS-1:0] raw;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_fade_channel #(
            .DATA_BITS (DATA_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .sleep_i   (mode_q.sleep),
            .step_i    (step),
            .fade_en_i (mode_q.fade_en),
            .target_i  (target_q[g]),
            .pwm_cnt_i (pwm_q),
            .mode_i    (ledout_q[g]),
            .raw_o     (raw[g])
        );
    end

    logic [NUM_LEDS-1:0]  leds_q, leds_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rvalid_q;

    assign leds_d = mode_q.sleep ? '0 : (raw ^ {NUM_LEDS{mode_q.invert}});

    always_comb begin
        rdata_d = '0;
        if (addr == ADDR_BITS'(REG_MODE_N)) begin
            rdata_d[2:0] = mode_q;
        end
        if (addr == ADDR_BITS'(REG_FADERATE)) begin
            rdata_d = faderate_q;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (addr == ADDR_BITS'(TARGET_BASE + i)) begin
                rdata_d = target_q[i];
            end
            if (addr == ADDR_BITS'(LEDOUT_BASE + i / 4)) begin
                rdata_d[2*(i%4) +: 2] = ledout_q[i];
            end
        end
    end

    // Read mux sees pre-write register values, so a same-cycle write+read returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            leds_q   <= leds_d;
            rvalid_q <= bus.r_en;
            if (bus.r_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign leds       = leds_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_led_controller_nch.sv
// Randomised bench for led_controller_nch, checked cycle by cycle against an arithmetic reference model.
module tb_led_controller_nch;
    import led_controller_nch_pkg::*;

    localparam int N      = 8;
    localparam int DW     = 8;
    localparam int P      = 2;
    localparam int AW     = addr_bits(N);
    localparam int PERIOD = P * (1 << DW);
    localparam int NREGS  = 2 + N + (N + 3) / 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] leds;

    led_controller_nch_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    led_controller_nch #(
        .NUM_LEDS  (N),
        .DATA_BITS (DW),
        .PRESCALE  (P)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] duty0;
    assign duty0 = dut.g_ch[0].u_ch.duty_q;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: register contents plus a single free-running waveform position.
    int           m_mode, m_fr, m_run, m_per, m_rdata;
    int           m_tgt [N];
    int           m_lo [N];
    int           m_duty [N];
    bit           m_rvalid = 1'b0;
    logic [N-1:0] m_leds = '0;

    function automatic int reg_value(input int a);
        int v;
        int base;
        if (a == 0) return m_mode;
        if (a == 1) return m_fr;
        if (a >= 2 && a < 2 + N) return m_tgt[a-2];
        if (a >= 2 + N && a < NREGS) begin
            v    = 0;
            base = 4 * (a - 2 - N);
            for (int j = 0; j < 4; j++)
                if (base + j < N) v |= m_lo[base+j] << (2 * j);
            return v;
        end
        return 0;
    endfunction

    task automatic model_step();
        int           pwm, a, d, base;
        bit           tick, wrap, slp, inv, fade, do_step;
        logic [N-1:0] raw;
        if (reset) begin
            m_mode = 0; m_fr = 0; m_run = 0; m_per = 0; m_rdata = 0;
            m_rvalid = 1'b0; m_leds = '0;
            for (int i = 0; i < N; i++) begin
                m_tgt[i] = 0; m_lo[i] = 0; m_duty[i] = 0;
            end
            return;
        end
        pwm  = (m_run / P) % (1 << DW);
        tick = (m_run % P) == P - 1;
        wrap = tick && (pwm == (1 << DW) - 1);
        slp  = m_mode[0];
        inv  = m_mode[1];
        fade = m_mode[2];
        for (int i = 0; i < N; i++)
            raw[i] = (m_lo[i] == 1) || (m_lo[i] == 2 && pwm < m_duty[i]);
        do_step = !slp && fade && wrap && (m_per >= m_fr);
        if (!slp) begin
            for (int i = 0; i < N; i++) begin
                if (!fade) m_duty[i] = m_tgt[i];
                else if (do_step && m_tgt[i] > m_duty[i]) m_duty[i]++;
                else if (do_step && m_tgt[i] < m_duty[i]) m_duty[i]--;
            end
        end
        if (slp || !fade) m_per = 0;
        else if (wrap) m_per = (m_per >= m_fr) ? 0 : m_per + 1;
        m_run  = slp ? 0 : (m_run + 1) % PERIOD;
        m_leds = slp ? '0 : (raw ^ {N{inv}});
        m_rvalid = bus.r_en;
        if (bus.r_en) m_rdata = reg_value(int'(bus.addr));
        if (bus.w_en) begin
            a = int'(bus.addr);
            d = int'(bus.wdata);
            if (a == 0) m_mode = d & 7;
            else if (a == 1) m_fr = d;
            else if (a >= 2 && a < 2 + N) m_tgt[a-2] = d;
            else if (a >= 2 + N && a < NREGS) begin
                base = 4 * (a - 2 - N);
                for (int j = 0; j < 4; j++)
                    if (base + j < N) m_lo[base+j] = (d >> (2 * j)) & 3;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("leds", leds, m_leds);
            check("rvalid", bus.rvalid, m_rvalid);
            check("rdata", bus.rdata, m_rdata);
        end
    end

    task automatic wr(input int a, input int d);
        bus.w_en  = 1'b1;
        bus.addr  = AW'(a);
        bus.wdata = DW'(d);
        @(negedge clk);
        bus.w_en  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int a, input int exp);
        bus.r_en = 1'b1;
        bus.addr = AW'(a);
        @(negedge clk);
        bus.r_en = 1'b0;
        check({tag, "_rvalid"}, bus.rvalid, 1);
        check(tag, bus.rdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic count_high(output int cnt);
        cnt = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if (leds[0]) cnt++;
        end
    endtask

    task automatic wait_duty_change(input string tag, output int cycles);
        logic [DW-1:0] prev;
        prev   = duty0;
        cycles = 0;
        while (duty0 == prev && cycles < 4 * PERIOD) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_in_time"}, (cycles < 4 * PERIOD), 1);
    endtask

    int cnt, cyc, frozen, op, a;

    initial begin
        reset     = 1'b1;
        bus.w_en  = 1'b0;
        bus.r_en  = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 16; i++) rd_check("reset_read", i, 0);
        wr(5, 8'h80);
        rd_check("target3_read", 5, 8'h80);
        wr(13, 8'h55);
        rd_check("unmapped_read", 13, 0);

        // ch0 on, ch1 off, ch2 reserved
        wr(10, 8'h31);
        repeat (4) @(negedge clk);
        check("static_modes", leds[2:0], 3'b001);
        wr(0, 2);
        check("invert_not_yet", leds[2:0], 3'b001);
        @(negedge clk);
        check("invert_t2", leds[2:0], 3'b110);

        wr(0, 0);
        wr(10, 8'h02);
        wr(2, 64);
        repeat (8) @(negedge clk);
        count_high(cnt);
        check("pwm_64", cnt, 64 * P);
        wr(2, 0);
        repeat (8) @(negedge clk);
        count_high(cnt);
        check("pwm_0", cnt, 0);
        wr(2, 255);
        repeat (8) @(negedge clk);
        count_high(cnt);
        check("pwm_255", cnt, PERIOD - P);

        do_reset();
        wr(10, 8'h02);
        wr(0, 4);
        wr(1, 1);
        wr(2, 4);
        for (int k = 1; k <= 4; k++) begin
            wait_duty_change("fade_up", cyc);
            check("fade_up_value", duty0, k);
            if (k > 1) check("fade_interval", cyc, 2 * PERIOD);
        end
        repeat (3 * PERIOD) @(negedge clk);
        check("fade_hold", duty0, 4);
        wr(2, 0);
        wait_duty_change("fade_down", cyc);
        check("fade_down_value", duty0, 3);
        wr(2, 2);
        wait_duty_change("retarget", cyc);
        check("retarget_value", duty0, 2);

        wr(2, 200);
        repeat (5 * PERIOD) @(negedge clk);
        wr(0, 7);
        @(negedge clk);
        frozen = int'(duty0);
        for (int i = 0; i < 12; i++) begin
            repeat (100) @(negedge clk);
            check("sleep_leds", leds, 0);
        end
        check("sleep_duty_frozen", duty0, frozen);
        wr(2, 8'h33);
        rd_check("sleep_target_read", 2, 8'h33);
        wr(0, 6);
        repeat (2 * PERIOD) @(negedge clk);

        wr(0, 0);
        wr(2, 8'h11);
        bus.w_en  = 1'b1;
        bus.r_en  = 1'b1;
        bus.addr  = AW'(2);
        bus.wdata = 8'h22;
        @(negedge clk);
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        check("collision_old", bus.rdata, 8'h11);
        rd_check("collision_new", 2, 8'h22);

        wr(10, 8'h55);
        wr(0, 4);
        wr(2, 200);
        repeat (3 * PERIOD) @(negedge clk);
        do_reset();
        check("reset_leds", leds, 0);
        check("reset_duty", duty0, 0);
        check("reset_rvalid", bus.rvalid, 0);
        check("reset_rdata", bus.rdata, 0);

        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            a  = $urandom_range(0, 15);
            if (op <= 4) begin
                if (a == 0) wr(a, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 6) & 6);
                else if (a == 1) wr(a, $urandom_range(0, 3));
                else wr(a, $urandom_range(0, 255));
            end else if (op <= 6) begin
                bus.r_en = 1'b1;
                bus.addr = AW'(a);
                @(negedge clk);
                bus.r_en = 1'b0;
            end else if (op == 7 && $urandom_range(0, 9) == 0) begin
                do_reset();
            end else begin
                repeat ($urandom_range(1, 300)) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
